// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serialiser FSM
// state encoding, line levels and a parity helper.
package uart_pkg;

    // Serialiser FSM states; PARITY is only reachable when UART_TX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int         DEFAULT_CLKS_PER_BIT = 10417;
    localparam logic       STOP_LEVEL           = 1'b1;
    localparam logic       START_LEVEL          = 1'b0;
    localparam logic [2:0] LAST_BIT_IDX         = 3'd7;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// byte_fifo: small first-word-fall-through byte queue. dout always shows the
// head entry, so the consumer can load it in the same cycle it pops.
// Pointers wrap modulo DEPTH (power of two); count is one bit wider.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // full/empty come from the registered count, so a pop while full frees
    // the slot only from the next cycle
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];

    // Storage array: written on accepted pushes, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 serial transmitter. Bytes are pushed on the
// rising edge of start, queued in byte_fifo and shifted out LSB-first on
// cereal. Defining UART_TX_PARITY_EN adds an even-parity bit (11-bit frame).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       full,
    output logic       status,
    output logic       overflow,
    output logic       cereal
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end

    logic              start_q;
    logic              push_req;
    logic              overflow_q;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    uart_state_e       state_q;
    uart_state_e       state_d;
    logic [BAUD_W-1:0] baud_cnt_q;
    logic              bit_tick;
    logic [7:0]        shift_q;
    logic [2:0]        bit_idx_q;
    logic              cereal_q;
    logic              cereal_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A level-held start must push only once, hence the edge detector
    assign push_req = start && !start_q;
    assign bit_tick = (baud_cnt_q == BAUD_W'(CLKS_PER_BIT - 1));

    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign cereal   = cereal_q;
    assign status   = (fifo_count == '0) && (state_q == IDLE);

    // Start edge detector and sticky overflow (push seen while full)
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            start_q <= start;
            if (push_req && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: each non-idle state lasts exactly one bit time
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!fifo_empty) state_d = START;
            START:  if (bit_tick)    state_d = DATA;
            DATA: begin
                if (bit_tick && (bit_idx_q == LAST_BIT_IDX)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: if (bit_tick)    state_d = STOP;
            STOP:   if (bit_tick)    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // FSM outputs: next line level and the FIFO pop when a frame begins
    always_comb begin
        fifo_pop = (state_q == IDLE) && !fifo_empty;
        cereal_d = STOP_LEVEL;
        case (state_q)
            START:  cereal_d = START_LEVEL;
            DATA:   cereal_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: cereal_d = parity_q;
`endif
            default: cereal_d = STOP_LEVEL;
        endcase
    end

    // Serialiser datapath: load on pop, then baud timing and right shifts
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            baud_cnt_q <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (state_q == IDLE) begin
            baud_cnt_q <= '0;
            if (fifo_pop) begin
                shift_q   <= fifo_dout;
                bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                parity_q  <= even_parity(fifo_dout);
`endif
            end
        end else begin
            baud_cnt_q <= bit_tick ? '0 : baud_cnt_q + 1'b1;
            if ((state_q == DATA) && bit_tick) begin
                shift_q   <= shift_q >> 1;
                bit_idx_q <= bit_idx_q + 1'b1;
            end
        end
    end

    // Registered line driver; reset forces the idle level at once
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cereal_q <= STOP_LEVEL;
        end else begin
            cereal_q <= cereal_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=4. A line
// monitor decodes frames by mid-bit sampling; the main sequence checks
// bytes, frame spacing, flags and the asynchronous reset behaviour.
// Build with +define+UART_TX_PARITY_EN to exercise the parity frame.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // back-to-back frame period: frame bits plus one IDLE cycle
    localparam int FRAME_CYC = FRAME_BITS * CPB + 1;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] data   = 8'h00;
    logic       start  = 1'b0;
    logic       full;
    logic       status;
    logic       overflow;
    logic       cereal;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rst_seen = 1'b0;

    logic [7:0] rx_q  [$];
    int         rx_t  [$];
    logic       rx_ok [$];
`ifdef UART_TX_PARITY_EN
    logic       rx_par [$];
`endif

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (4)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .data     (data),
        .start    (start),
        .full     (full),
        .status   (status),
        .overflow (overflow),
        .cereal   (cereal)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge rst);
            rst_seen = 1'b1;
        end
    end

    // Line monitor: start bit seen at negedge k, each bit sampled 2 cycles into its 4-cycle slot
    initial begin : rx_monitor
        logic       prev;
        logic [7:0] b;
        logic       sb;
        logic       stp;
        logic       par;
        int         k;
        prev = 1'b1;
        b    = '0;
        par  = 1'b0;
        forever begin
            @(negedge sysclk);
            if (!rst && prev && !cereal) begin
                k = cyc;
                rst_seen = 1'b0;
                repeat (2) @(negedge sysclk);
                sb = cereal;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge sysclk);
                    b[i] = cereal;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge sysclk);
                par = cereal;
`endif
                repeat (CPB) @(negedge sysclk);
                stp = cereal;
                if (rst_seen) begin
                    $display("rx: frame starting at cycle %0d cut by reset", k);
                end else begin
                    rx_q.push_back(b);
                    rx_t.push_back(k);
                    rx_ok.push_back((sb == 1'b0) && (stp == 1'b1));
`ifdef UART_TX_PARITY_EN
                    rx_par.push_back(par);
`endif
                    $display("rx: byte=%02h start_cycle=%0d startbit=%0b stopbit=%0b par=%0b", b, k, sb, stp, par);
                end
            end
            prev = cereal;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge sysclk);
        data  = b;
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        $display("push: byte=%02h full=%0b overflow=%0b", b, full, overflow);
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while ((rx_q.size() < n) && (c < budget)) begin
            @(negedge sysclk);
            c++;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_ok.delete();
`ifdef UART_TX_PARITY_EN
        rx_par.delete();
`endif
    endtask

    initial begin : main
        logic [7:0] exp4 [5];
        exp4[0] = 8'h46; exp4[1] = 8'h50; exp4[2] = 8'h47; exp4[3] = 8'h41;

        // ---- reset state ----
        repeat (3) @(negedge sysclk);
        check("rst_cereal", cereal, 1'b1);
        check("rst_status", status, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge sysclk);

        // ---- 1: single byte 0x45, latency and frame ----
        clear_rx();
        push_byte(8'h45);
        check("t1_status_busy", status, 1'b0);
        @(negedge sysclk);
        check("t1_cereal_n1", cereal, 1'b1);
        @(negedge sysclk);
        check("t1_cereal_n2", cereal, 1'b0);
        wait_rx(1, 100, "t1_rx_count");
        check("t1_byte", rx_q[0], 8'h45);
        check("t1_framing", rx_ok[0], 1'b1);
        repeat (2) @(negedge sysclk);
        check("t1_status_done", status, 1'b1);
        check("t1_cereal_idle", cereal, 1'b1);

        // ---- 2: start held high 20 cycles -> one frame ----
        clear_rx();
        @(negedge sysclk);
        data  = 8'h4E;
        start = 1'b1;
        repeat (20) @(negedge sysclk);
        start = 1'b0;
        wait_rx(1, 100, "t2_rx_count");
        repeat (60) @(negedge sysclk);
        check("t2_single_frame", rx_q.size(), 1);
        check("t2_byte", rx_q[0], 8'h4E);
        check("t2_overflow", overflow, 1'b0);

        // ---- 3: burst F,P,G,A -> in order, 1-cycle idle gap ----
        clear_rx();
        for (int i = 0; i < 4; i++) push_byte(exp4[i]);
        wait_rx(4, 400, "t3_rx_count");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_byte%0d", i), rx_q[i], exp4[i]);
            check($sformatf("t3_framing%0d", i), rx_ok[i], 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_gap%0d", i), rx_t[i+1] - rx_t[i], FRAME_CYC);
        end
        repeat (3) @(negedge sysclk);
        check("t3_status", status, 1'b1);

        // ---- 4: five pushes while first frame active, then a sixth ----
        clear_rx();
        for (int i = 0; i < 5; i++) push_byte(8'h31 + 8'(i));
        check("t4_full", full, 1'b1);
        check("t4_overflow_clear", overflow, 1'b0);
        push_byte(8'h36);
        check("t4_overflow_set", overflow, 1'b1);
        wait_rx(5, 600, "t4_rx_count");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_byte%0d", i), rx_q[i], 8'h31 + 8'(i));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_gap%0d", i), rx_t[i+1] - rx_t[i], FRAME_CYC);
        end
        repeat (60) @(negedge sysclk);
        check("t4_no_dropped_byte", rx_q.size(), 5);
        check("t4_overflow_sticky", overflow, 1'b1);
        check("t4_full_drained", full, 1'b0);

        // ---- 5: async reset during DATA bit 3 ----
        clear_rx();
        push_byte(8'h55);
        push_byte(8'h66);
        push_byte(8'h77);
        // push of 0x55 at edge N; bit 3 is on the line N+18..N+22, now at N+4.5
        repeat (14) @(negedge sysclk);
        check("t5_bit3_low", cereal, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_cereal_async", cereal, 1'b1);
        check("t5_status_async", status, 1'b1);
        check("t5_full_async", full, 1'b0);
        check("t5_overflow_cleared", overflow, 1'b0);
        @(negedge sysclk);
        rst = 1'b0;
        repeat (100) @(negedge sysclk);
        check("t5_queue_discarded", rx_q.size(), 0);
        check("t5_cereal_idle", cereal, 1'b1);
        check("t5_status_idle", status, 1'b1);

`ifdef UART_TX_PARITY_EN
        // ---- 6: even parity bits ----
        clear_rx();
        push_byte(8'h45);
        push_byte(8'h41);
        wait_rx(2, 200, "t6_rx_count");
        check("t6_byte0", rx_q[0], 8'h45);
        check("t6_par0", rx_par[0], 1'b1);
        check("t6_byte1", rx_q[1], 8'h41);
        check("t6_par1", rx_par[1], 1'b0);
        check("t6_gap", rx_t[1] - rx_t[0], FRAME_CYC);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
